// File: rtl/mmem_access_ctrl.sv
// mmem_access_ctrl: requester-side controller for the dual-port mmem RAM.
// Client 0 drives RAM port A and client 1 drives RAM port B. After reset the
// controller writes INIT_VALUE to every RAM word before accepting client traffic.
// Only one write reaches the RAM per cycle, and client 0 wins a write collision.
//
// Handshake: a client request transfers in any cycle where valid and ready are
// both 1. ready is combinational from state, valid and we. The client holds its
// fields stable until ready. Read data returns one cycle after acceptance,
// flagged by a single-cycle rvalid. rdata then holds until the next read.
//
// Optional build macro MMEM_WR_FWD_EN: a read that hits the address written by
// the other client in the same cycle returns the newly written data instead of
// the RAM's old data.
module mmem_access_ctrl #(
    parameter int              AW         = 5,
    parameter int              DW         = 32,
    parameter logic [DW-1:0]   INIT_VALUE = '0
) (
    input  logic          clk_a,
    input  logic          reset,
    input  logic          c0_valid,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_ready,
    output logic          c0_rvalid,
    output logic [DW-1:0] c0_rdata,
    input  logic          c1_valid,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_ready,
    output logic          c1_rvalid,
    output logic [DW-1:0] c1_rdata,
    output logic          init_done,
    output logic [AW-1:0] ram_address_a,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_wren_a,
    output logic          ram_rden_a,
    input  logic [DW-1:0] ram_q_a,
    output logic [AW-1:0] ram_address_b,
    output logic [DW-1:0] ram_data_b,
    output logic          ram_wren_b,
    output logic          ram_rden_b,
    input  logic [DW-1:0] ram_q_b
);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          rd0, wr0, rd1, wr1;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] hold0_q, hold1_q;
    logic [DW-1:0] rsrc0, rsrc1;

    // State register and clear counter.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk the clear counter over all words, then run forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                if (cnt_q == {AW{1'b1}}) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Handshake and RAM issue. A stalled client 1 write leaves port B idle.
    always_comb begin
        c0_ready      = (state_q == S_RUN);
        c1_ready      = (state_q == S_RUN) & ~(c0_valid & c0_we & c1_we);
        rd0           = c0_valid & c0_ready & ~c0_we;
        wr0           = c0_valid & c0_ready &  c0_we;
        rd1           = c1_valid & c1_ready & ~c1_we;
        wr1           = c1_valid & c1_ready &  c1_we;
        ram_wren_a    = 1'b0;
        ram_rden_a    = 1'b0;
        ram_address_a = c0_addr;
        ram_data_a    = c0_wdata;
        ram_wren_b    = wr1;
        ram_rden_b    = rd1;
        ram_address_b = c1_addr;
        ram_data_b    = c1_wdata;
        if (state_q == S_CLEAR) begin
            // Clear writes are held off while reset is still asserted.
            ram_wren_a    = ~reset;
            ram_address_a = cnt_q;
            ram_data_a    = INIT_VALUE;
        end else begin
            ram_wren_a = wr0;
            ram_rden_a = rd0;
        end
    end

    assign init_done = (state_q == S_RUN);

`ifdef MMEM_WR_FWD_EN
    logic          fwd0_q, fwd1_q;
    logic [DW-1:0] fwd_data0_q, fwd_data1_q;

    // Capture a cross-client write that hits the address being read this cycle.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            fwd0_q      <= 1'b0;
            fwd1_q      <= 1'b0;
            fwd_data0_q <= '0;
            fwd_data1_q <= '0;
        end else begin
            fwd0_q      <= rd0 & wr1 & (c0_addr == c1_addr);
            fwd1_q      <= rd1 & wr0 & (c1_addr == c0_addr);
            fwd_data0_q <= c1_wdata;
            fwd_data1_q <= c0_wdata;
        end
    end

    assign rsrc0 = fwd0_q ? fwd_data0_q : ram_q_a;
    assign rsrc1 = fwd1_q ? fwd_data1_q : ram_q_b;
`else
    assign rsrc0 = ram_q_a;
    assign rsrc1 = ram_q_b;
`endif

    // Read return: rvalid one cycle after acceptance, rdata held between reads.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
            hold0_q   <= c0_rdata;
            hold1_q   <= c1_rdata;
        end
    end

    assign c0_rvalid = rvalid0_q;
    assign c1_rvalid = rvalid1_q;
    assign c0_rdata  = rvalid0_q ? rsrc0 : hold0_q;
    assign c1_rdata  = rvalid1_q ? rsrc1 : hold1_q;

endmodule
